// File: rtl/ram2ddr_pkg.sv
// Shared types and constants for the SRAM-to-DDR bridge: FSM states and
// user-port command codes.
package ram2ddr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_WAIT = 3'd2,
    RD_CMD  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  localparam int LANE_W = 16;

endpackage

// File: rtl/ram2ddr_xadc_if.sv
// Memory-controller user port (command, write-data and read-data channels).
// master = bridge side, slave = controller side.
interface ram2ddr_xadc_if #(
  parameter int RAM_ADDR_W = 27,
  parameter int APP_DATA_W = 128
);
  logic [RAM_ADDR_W-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [APP_DATA_W-1:0]   app_wdf_data;
  logic [APP_DATA_W/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [APP_DATA_W-1:0]   app_rd_data;
  logic                    app_rd_data_valid;
  logic                    init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           init_calib_complete
  );
endinterface

// File: rtl/ram2ddr_sync.sv
// Input capture stage for the SRAM-side pins. RAM2DDR_INSYNC_EN selects a
// two-flop synchronizer; otherwise a single register stage.
module ram2ddr_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef RAM2DDR_INSYNC_EN
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end
`endif

endmodule

// File: rtl/ram2ddr_xadc.sv
// Bridges an asynchronous 16-bit SRAM-style port onto a DDR controller user
// port. Input capture depth is set by RAM2DDR_INSYNC_EN (see ram2ddr_sync).
module ram2ddr_xadc
  import ram2ddr_pkg::*;
#(
  parameter int RAM_ADDR_W = 27,
  parameter int APP_DATA_W = 128
) (
  input  logic                  clk_200MHz_i,
  input  logic                  rst_i,
  input  logic [11:0]           device_temp_i,
  output logic [11:0]           device_temp_o,
  input  logic [RAM_ADDR_W-1:0] ram_a,
  input  logic [15:0]           ram_dq_i,
  output logic [15:0]           ram_dq_o,
  input  logic                  ram_cen,
  input  logic                  ram_oen,
  input  logic                  ram_wen,
  input  logic                  ram_ub,
  input  logic                  ram_lb,
  output logic                  busy_o,
  ram2ddr_xadc_if.master        app
);

  localparam int LANES  = APP_DATA_W / LANE_W;
  localparam int MASK_W = APP_DATA_W / 8;
  localparam int IN_W   = (RAM_ADDR_W - 1) + 16 + 5;

  logic [IN_W-1:0]       in_raw;
  logic [IN_W-1:0]       in_s;
  logic [RAM_ADDR_W-1:1] a_s;
  logic [15:0]           dq_s;
  logic                  ub_s, lb_s, wen_s, oen_s, cen_s;
  logic                  unused_a0;

  // Strobes reset to their deasserted (high) level so reset never looks like a cen edge.
  assign in_raw = {ram_a[RAM_ADDR_W-1:1], ram_dq_i, ram_ub, ram_lb, ram_wen, ram_oen, ram_cen};
  assign unused_a0 = ram_a[0];

  ram2ddr_sync #(
    .WIDTH   (IN_W),
    .RST_VAL ({{(IN_W-5){1'b0}}, 5'b11111})
  ) u_sync (
    .clk   (clk_200MHz_i),
    .rst_n (rst_i),
    .d     (in_raw),
    .q     (in_s)
  );

  assign {a_s, dq_s, ub_s, lb_s, wen_s, oen_s, cen_s} = in_s;

  state_t                state, state_nxt;
  logic                  cen_hist;
  logic                  cmd_done, wdf_done;
  logic [15:0]           data_r;
  logic [2:0]            lane_r;
  logic [RAM_ADDR_W-1:0] addr_r;
  logic [MASK_W-1:0]     mask_r, mask_nxt;
  logic [15:0]           dq_r, rd_word;
  logic [11:0]           temp_r;
  logic                  en_c, wren_c;
  logic [2:0]            cmd_c;
  logic                  cen_fall, start_wr, start_rd, cmd_ok, wdf_ok, leave_idle;

  assign cen_fall = cen_hist & ~cen_s;
  assign start_wr = app.init_calib_complete & cen_fall & ~wen_s;
  assign start_rd = app.init_calib_complete & cen_fall & ~oen_s & wen_s;
  assign cmd_ok   = cmd_done | app.app_rdy;
  assign wdf_ok   = wdf_done | app.app_wdf_rdy;

  always_ff @(posedge clk_200MHz_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    wren_c    = 1'b0;
    cmd_c     = APP_CMD_WRITE;
    case (state)
      IDLE: begin
        if (start_wr)      state_nxt = WR_CMD;
        else if (start_rd) state_nxt = RD_CMD;
      end
      // Command and write-data channels handshake independently.
      WR_CMD, WR_WAIT: begin
        en_c   = ~cmd_done;
        wren_c = ~wdf_done;
        if (cmd_ok && wdf_ok)      state_nxt = DONE;
        else if (cmd_ok || wdf_ok) state_nxt = WR_WAIT;
      end
      RD_CMD: begin
        en_c  = 1'b1;
        cmd_c = APP_CMD_READ;
        if (app.app_rdy) state_nxt = RD_WAIT;
      end
      RD_WAIT: if (app.app_rd_data_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign leave_idle = (state == IDLE) && (state_nxt != IDLE);

  always_comb begin
    mask_nxt = '1;
    for (int i = 0; i < LANES; i++) begin
      if (a_s[3:1] == 3'(i)) begin
        mask_nxt[2*i]   = lb_s;
        mask_nxt[2*i+1] = ub_s;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_r == 3'(i)) rd_word = app.app_rd_data[LANE_W*i +: LANE_W];
    end
  end

  always_ff @(posedge clk_200MHz_i or negedge rst_i) begin
    if (!rst_i) begin
      cen_hist <= 1'b1;
      cmd_done <= 1'b0;
      wdf_done <= 1'b0;
      data_r   <= '0;
      lane_r   <= '0;
      addr_r   <= '0;
      mask_r   <= '1;
      dq_r     <= '0;
      temp_r   <= '0;
    end else begin
      cen_hist <= cen_s;
      temp_r   <= device_temp_i;
      if (state == WR_CMD || state == WR_WAIT) begin
        if (app.app_rdy)     cmd_done <= 1'b1;
        if (app.app_wdf_rdy) wdf_done <= 1'b1;
      end else begin
        cmd_done <= 1'b0;
        wdf_done <= 1'b0;
      end
      if (leave_idle) begin
        data_r <= dq_s;
        lane_r <= a_s[3:1];
        addr_r <= {a_s[RAM_ADDR_W-1:4], 4'b0000};
        mask_r <= mask_nxt;
      end
      if (state == RD_WAIT && app.app_rd_data_valid) dq_r <= rd_word;
    end
  end

  assign app.app_en       = en_c;
  assign app.app_cmd      = cmd_c;
  assign app.app_addr     = addr_r;
  assign app.app_wdf_data = {LANES{data_r}};
  assign app.app_wdf_mask = mask_r;
  assign app.app_wdf_wren = wren_c;
  assign app.app_wdf_end  = wren_c;

  assign ram_dq_o      = dq_r;
  assign device_temp_o = temp_r;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_ram2ddr_xadc.sv
// Bench for ram2ddr_xadc: SRAM-level word model, controller memory model and
// a per-cycle monitor of the user-port handshakes.
module tb_ram2ddr_xadc;
  import ram2ddr_pkg::*;

  localparam int AW = 27;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [11:0]   device_temp_i, device_temp_o;
  logic [AW-1:0] ram_a;
  logic [15:0]   ram_dq_i, ram_dq_o;
  logic          ram_cen, ram_oen, ram_wen, ram_ub, ram_lb, busy_o;

  always #5 clk = ~clk;

  ram2ddr_xadc_if #(.RAM_ADDR_W(AW), .APP_DATA_W(DW)) app_bus ();

  ram2ddr_xadc #(.RAM_ADDR_W(AW), .APP_DATA_W(DW)) dut (
    .clk_200MHz_i  (clk),
    .rst_i         (rst_i),
    .device_temp_i (device_temp_i),
    .device_temp_o (device_temp_o),
    .ram_a         (ram_a),
    .ram_dq_i      (ram_dq_i),
    .ram_dq_o      (ram_dq_o),
    .ram_cen       (ram_cen),
    .ram_oen       (ram_oen),
    .ram_wen       (ram_wen),
    .ram_ub        (ram_ub),
    .ram_lb        (ram_lb),
    .busy_o        (busy_o),
    .app           (app_bus)
  );

  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [15:0] mask; } wdf_exp_t;

  int checks = 0, failures = 0, cmd_count = 0, wdf_count = 0;
  cmd_exp_t cmd_q[$];
  wdf_exp_t wdf_q[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [15:0]   sram [logic [AW-1:0]];
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_mask = '0;
  bit            auto_resp = 1'b1, man_valid = 1'b0;
  logic [DW-1:0] man_data = '0;
  int            rd_dly = 3;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Unwritten controller lines hold a lane-tagged pattern so a wrong lane is visible.
  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] addr);
    logic [DW-1:0] l;
    logic [15:0]   w;
    if (mem.exists(addr)) return mem[addr];
    for (int i = 0; i < 8; i++) begin
      w = 16'hE000 + 16'(i);
      l[16*i +: 16] = w;
    end
    return l;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
    logic [AW-1:0] key;
    key = {a[AW-1:1], 1'b0};
    if (sram.exists(key)) return sram[key];
    return 16'hE000 + 16'(a[3:1]);
  endfunction

  function automatic logic [15:0] exp_mask(input logic [AW-1:0] a, input bit ub, input bit lb);
    logic [15:0] m;
    int w;
    m = 16'hFFFF;
    w = int'(a[3:1]);
    m[2*w]   = lb;
    m[2*w+1] = ub;
    return m;
  endfunction

  // Handshakes are sampled at the falling edge; all stimulus changes 1 ns after the rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      chk("wdf_end_tracks_wren", app_bus.app_wdf_end, app_bus.app_wdf_wren);
      if (app_bus.app_en && app_bus.app_rdy) begin
        cmd_count++;
        last_addr = app_bus.app_addr;
        if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
        else begin
          cmd_exp_t e;
          e = cmd_q.pop_front();
          chk("cmd_code", app_bus.app_cmd, e.cmd);
          chk("cmd_addr", app_bus.app_addr, e.addr);
          if (e.cmd == APP_CMD_READ) rd_q.push_back(e.addr);
        end
      end
      if (app_bus.app_wdf_wren && app_bus.app_wdf_rdy) begin
        wdf_count++;
        last_mask = app_bus.app_wdf_mask;
        if (wdf_q.size() == 0) chk("unexpected_wdf", 1, 0);
        else begin
          wdf_exp_t e;
          logic [DW-1:0] l;
          e = wdf_q.pop_front();
          chk("wdf_data", app_bus.app_wdf_data, e.data);
          chk("wdf_mask", app_bus.app_wdf_mask, e.mask);
          l = line_of(e.addr);
          for (int j = 0; j < 16; j++)
            if (!app_bus.app_wdf_mask[j]) l[8*j +: 8] = app_bus.app_wdf_data[8*j +: 8];
          mem[e.addr] = l;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    app_bus.app_rd_data_valid = man_valid;
    app_bus.app_rd_data       = man_valid ? man_data : '0;
    if (auto_resp && rd_q.size() > 0) begin
      if (rd_dly == 0) begin
        app_bus.app_rd_data_valid = 1'b1;
        app_bus.app_rd_data       = line_of(rd_q.pop_front());
        rd_dly = 3;
      end else rd_dly--;
    end
  end

  task automatic wait_busy(input bit level, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy_o === level) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic expect_op(input bit is_wr, input logic [AW-1:0] a, input logic [15:0] d,
                           input bit ub, input bit lb);
    cmd_exp_t c;
    wdf_exp_t w;
    logic [15:0] old;
    c.cmd  = is_wr ? APP_CMD_WRITE : APP_CMD_READ;
    c.addr = {a[AW-1:4], 4'b0000};
    cmd_q.push_back(c);
    if (is_wr) begin
      w.addr = c.addr;
      w.data = {8{d}};
      w.mask = exp_mask(a, ub, lb);
      wdf_q.push_back(w);
      old = sram_rd(a);
      if (!lb) old[7:0]  = d[7:0];
      if (!ub) old[15:8] = d[15:8];
      sram[{a[AW-1:1], 1'b0}] = old;
    end
  endtask

  task automatic drive_op(input bit is_wr, input logic [AW-1:0] a, input logic [15:0] d,
                          input bit ub, input bit lb);
    @(posedge clk); #1;
    ram_a    = a;
    ram_dq_i = d;
    ram_ub   = ub;
    ram_lb   = lb;
    ram_wen  = ~is_wr;
    ram_oen  = is_wr;
    ram_cen  = 1'b0;
  endtask

  task automatic release_strobes();
    @(posedge clk); #1;
    ram_cen = 1'b1;
    ram_wen = 1'b1;
    ram_oen = 1'b1;
    ram_ub  = 1'b1;
    ram_lb  = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_op(input bit is_wr, input logic [AW-1:0] a, input logic [15:0] d,
                       input bit ub, input bit lb, input int hold);
    int c0;
    c0 = cmd_count;
    expect_op(is_wr, a, d, ub, lb);
    drive_op(is_wr, a, d, ub, lb);
    wait_busy(1'b1, 20, "op_start_timeout");
    wait_busy(1'b0, 100, "op_done_timeout");
    repeat (hold) @(posedge clk);
    release_strobes();
    @(negedge clk);
    chk("one_cmd_per_op", cmd_count - c0, 1);
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [15:0] lit);
    do_op(1'b0, a, 16'h0000, 1'b1, 1'b1, 0);
    chk("rd_vs_model", ram_dq_o, sram_rd(a));
    chk("rd_literal", ram_dq_o, lit);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy_o, 0);
    chk("rst_dq_o", ram_dq_o, 0);
    chk("rst_app_en", app_bus.app_en, 0);
    chk("rst_wren", app_bus.app_wdf_wren, 0);
    chk("rst_wend", app_bus.app_wdf_end, 0);
    chk("rst_cmd", app_bus.app_cmd, 0);
    chk("rst_addr", app_bus.app_addr, 0);
    chk("rst_mask", app_bus.app_wdf_mask, 16'hFFFF);
    chk("rst_temp", device_temp_o, 0);
  endtask

  initial begin
    int c0, w0;
    ram_cen = 1'b1; ram_oen = 1'b1; ram_wen = 1'b1; ram_ub = 1'b1; ram_lb = 1'b1;
    ram_a = '0; ram_dq_i = '0; device_temp_i = 12'h5A5;
    app_bus.init_calib_complete = 1'b0;
    app_bus.app_rdy = 1'b1;
    app_bus.app_wdf_rdy = 1'b1;
    app_bus.app_rd_data = '0;
    app_bus.app_rd_data_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();

    @(posedge clk); #1;
    rst_i = 1'b1;
    app_bus.init_calib_complete = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("temp_copy", device_temp_o, 12'h5A5);

    do_op(1'b1, 27'h0000200, 16'h1236, 1'b0, 1'b0, 0);
    chk("wr_200_addr", last_addr, 27'h0000200);
    chk("wr_200_mask", last_mask, 16'hFFFC);
    do_rd(27'h0000200, 16'h1236);

    do_op(1'b1, 27'h0400108, 16'h4444, 1'b0, 1'b0, 0);
    chk("wr_hi_addr", last_addr, 27'h0400100);
    chk("wr_hi_mask", last_mask, 16'hFCFF);
    do_rd(27'h0400108, 16'h4444);

    do_op(1'b1, 27'h0000088, 16'h2222, 1'b0, 1'b0, 0);
    do_rd(27'h0000088, 16'h2222);
    do_rd(27'h0000086, 16'hE003);

    // Back-pressure: command ready low 10 cycles, write-data ready low 3 cycles.
    c0 = cmd_count;
    w0 = wdf_count;
    expect_op(1'b1, 27'h0000012, 16'h5A5A, 1'b0, 1'b1);
    @(posedge clk); #1;
    app_bus.app_rdy = 1'b0;
    app_bus.app_wdf_rdy = 1'b0;
    drive_op(1'b1, 27'h0000012, 16'h5A5A, 1'b0, 1'b1);
    wait_busy(1'b1, 20, "bp_start_timeout");
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_app_en_held", app_bus.app_en, 1);
      chk("bp_wren_until_rdy", app_bus.app_wdf_wren, (i < 3) ? 1 : 0);
      if (i == 1) begin @(posedge clk); #1; app_bus.app_wdf_rdy = 1'b1; end
      if (i == 8) begin @(posedge clk); #1; app_bus.app_rdy = 1'b1; end
    end
    wait_busy(1'b0, 20, "bp_done_timeout");
    release_strobes();
    @(negedge clk);
    chk("bp_cmd_count", cmd_count - c0, 1);
    chk("bp_wdf_count", wdf_count - w0, 1);
    chk("bp_mask", last_mask, 16'hFFF7);
    do_rd(27'h0000012, 16'h5A01);

    // Gating: no calibration, then calibration with no fresh cen edge.
    c0 = cmd_count;
    @(posedge clk); #1;
    app_bus.init_calib_complete = 1'b0;
    drive_op(1'b1, 27'h0000040, 16'h1111, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("gate_nocal_cmds", cmd_count - c0, 0);
    chk("gate_nocal_busy", busy_o, 0);
    @(posedge clk); #1;
    app_bus.init_calib_complete = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("gate_noedge_cmds", cmd_count - c0, 0);
    chk("gate_noedge_busy", busy_o, 0);
    release_strobes();

    do_op(1'b1, 27'h0000030, 16'h0BEE, 1'b0, 1'b0, 10);
    do_rd(27'h0000030, 16'h0BEE);

    // Reset while waiting for read data; a late valid must not load ram_dq_o.
    auto_resp = 1'b0;
    c0 = cmd_count;
    expect_op(1'b0, 27'h0000088, 16'h0000, 1'b1, 1'b1);
    drive_op(1'b0, 27'h0000088, 16'h0000, 1'b1, 1'b1);
    wait_busy(1'b1, 20, "rst_op_start_timeout");
    for (int i = 0; i < 20 && cmd_count == c0; i++) @(negedge clk);
    chk("rst_op_cmd_issued", cmd_count - c0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    ram_cen = 1'b1; ram_oen = 1'b1; ram_wen = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    man_data  = {8{16'h7777}};
    man_valid = 1'b1;
    @(posedge clk); #1;
    man_valid = 1'b0;
    c0 = cmd_count;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("late_valid_dq_o", ram_dq_o, 0);
    chk("late_valid_busy", busy_o, 0);
    chk("after_rst_no_cmd", cmd_count - c0, 0);
    rd_q.delete();
    auto_resp = 1'b1;

    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("wdf_queue_drained", wdf_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram2ddr_xadc.md
RAM2DDR_XADC -- requirements
Module: ram2ddr_xadc

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 27, meaning byte address width of the SRAM-side port.
REQ-002 SHALL have parameter APP_DATA_W, default 128, meaning the controller user-port data width; mask width is APP_DATA_W/8.
REQ-003 SHALL have a single clock and an asynchronous active-low reset: clk_200MHz_i and rst_i.
REQ-004 clk_200MHz_i  in  1  200 MHz system clock; all logic is on its rising edge.
REQ-005 rst_i  in  1  asynchronous active-low reset.
REQ-006 device_temp_i  in  12  XADC temperature; device_temp_o  out  12  registered copy for the controller.
REQ-007 ram_a  in  RAM_ADDR_W  byte address; bit 0 is ignored.
REQ-008 ram_dq_i  in  16  write data; ram_dq_o  out  16  read data.
REQ-009 ram_cen, ram_oen, ram_wen, ram_ub, ram_lb  in  1 each  active-low chip enable, output enable, write enable, upper byte and lower byte enables.
REQ-010 app_addr  out  RAM_ADDR_W; app_cmd  out  3 (000 write, 001 read); app_en  out  1; app_rdy  in  1.
REQ-011 app_wdf_data  out  APP_DATA_W; app_wdf_mask  out  APP_DATA_W/8 (1 = masked); app_wdf_wren and app_wdf_end  out  1; app_wdf_rdy  in  1.
REQ-012 app_rd_data  in  APP_DATA_W; app_rd_data_valid  in  1; init_calib_complete  in  1; busy_o  out  1 (high whenever not IDLE).

Function
REQ-013 SHALL use FSM states IDLE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT and DONE.
REQ-014 IDLE SHALL go to WR_CMD when init_calib_complete=1 and registered cen=0, wen=0 and a cen high-to-low edge is seen.
REQ-015 IDLE SHALL go to RD_CMD when init_calib_complete=1 and registered cen=0, oen=0, wen=1 and a cen high-to-low edge is seen.
REQ-016 In all other cases, including cen held low after DONE, IDLE SHALL stay idle.
REQ-017 On leaving IDLE, the block SHALL latch address, data, ub and lb.
REQ-018 app_addr SHALL be {ram_a[RAM_ADDR_W-1:4], 4'b0000}.
REQ-019 The word lane SHALL be w = ram_a[3:1].
REQ-020 app_wdf_data SHALL replicate ram_dq_i across all eight 16-bit lanes.
REQ-021 app_wdf_mask SHALL be all ones, except bit 2w = ram_lb and bit 2w+1 = ram_ub.
REQ-022 WR_CMD SHALL assert app_en and app_wdf_wren/app_wdf_end in the same cycle.
REQ-023 In WR_CMD, each signal SHALL hold until its own ready (app_rdy or app_wdf_rdy) is seen high at a rising edge; the two handshakes complete independently.
REQ-024 WR_CMD SHALL go to DONE when both handshakes are complete.
REQ-025 RD_CMD SHALL hold app_en=1 with app_cmd=001 until app_rdy=1, then go to RD_WAIT.
REQ-026 RD_WAIT SHALL wait for app_rd_data_valid=1 in the first beat, load ram_dq_o with app_rd_data[16w+15:16w], and go to DONE.
REQ-027 ram_dq_o SHALL hold its value until the next read completes.
REQ-028 DONE SHALL return to IDLE on the next cycle.
REQ-029 A new operation SHALL require cen to go high and then low again.
REQ-030 Changes to cen, oen or wen during an operation SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-031 While rst_i=0: FSM=IDLE, ram_dq_o=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, app_cmd=000, app_addr=0, app_wdf_mask all ones, device_temp_o=0.
REQ-032 While rst_i=0, the cen history register SHALL be 1 (deasserted).
REQ-033 Reset asserted mid-operation SHALL abort to IDLE with no further app_en.

Configuration
REQ-034 The macro RAM2DDR_INSYNC_EN SHALL select how SRAM-side inputs are captured.
REQ-035 With RAM2DDR_INSYNC_EN defined, all SRAM-side inputs SHALL pass through a two-flop synchronizer, so detection latency is 2 cycles.
REQ-036 Without RAM2DDR_INSYNC_EN, the inputs SHALL pass through one register, so detection latency is 1 cycle.

Structure
REQ-037 A shared package ram2ddr_pkg SHALL hold the FSM state enum and the APP_CMD_WRITE/APP_CMD_READ constants.
REQ-038 The synchronizer SHALL be a sub-module ram2ddr_sync, parameterized by width and compiled per RAM2DDR_INSYNC_EN.

Verification
REQ-039 Write then read: write ram_a=0x0000200, data 0x1236, ub=lb=0 -> one app write with app_addr=0x0000200 and mask 0xFFFC; then read 0x0000200 with the model returning the same data -> ram_dq_o=0x1236.
REQ-040 High address: write 0x4444 at ram_a=0x0400108 -> app_addr=0x0400100, w=4, mask 0xFCFF; read back -> ram_dq_o=0x4444.
REQ-041 Lane select: write 0x2222 at ram_a=0x0000088 -> w=4; read back -> 0x2222, with no other lane returned.
REQ-042 Back-pressure: app_rdy=0 for 10 cycles and app_wdf_rdy=0 for 3 cycles -> app_en and app_wdf_wren each stay high until their own ready; exactly one command is issued.
REQ-043 Gating: init_calib_complete=0 with cen=0 -> no app_en; cen held low after DONE -> no second command.
REQ-044 Reset: rst_i=0 in RD_WAIT -> FSM=IDLE, ram_dq_o=0; a late app_rd_data_valid is ignored.
